// File: rtl/eth_tx_mux_n.sv
// eth_tx_mux_n
// N-to-1 GMII transmit multiplexer. Arbitrates between CH_NUM frame sources
// (fixed priority or round-robin), forwards the granted channel's GMII stream
// with one cycle of latency, enforces an inter-frame gap, and flags start
// timeouts and collisions from non-granted channels.
module eth_tx_mux_n #(
    parameter int CH_NUM        = 2,   // number of transmit sources, 2..8
    parameter int ARB_MODE      = 0,   // 0 = fixed priority, 1 = round-robin
    parameter int IFG_CYCLES    = 12,  // idle cycles forced between frames, 1..255
    parameter int START_TIMEOUT = 64   // GRANT cycles allowed before tx_en, 1..1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH_NUM-1:0]     ch_req,
    input  logic [CH_NUM-1:0]     ch_tx_en,
    input  logic [8*CH_NUM-1:0]   ch_txd,
    output logic [CH_NUM-1:0]     ch_grant,
    output logic                  gmii_tx_en,
    output logic [7:0]            gmii_txd,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  collision_err
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int IW = $clog2(CH_NUM);
    localparam int WW = $clog2(START_TIMEOUT + 1);
    localparam int GW = $clog2(IFG_CYCLES + 1);

    // Round-robin pointer holds the last granted index; resetting it to the
    // top channel makes channel 0 the first one searched.
    localparam logic [IW-1:0] RR_RST    = IW'(CH_NUM - 1);

    // Counters stop one short of their limit, so they never reach a value
    // that could wrap.
    localparam logic [WW-1:0] WAIT_LAST = WW'(START_TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(IFG_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_SEND  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,       state_d;
    logic [CH_NUM-1:0] grant_q,       grant_d;
    logic              tx_en_q,       tx_en_d;
    logic [7:0]        txd_q,         txd_d;
    logic              timeout_q,     timeout_d;
    logic              collision_q,   collision_d;
    logic [WW-1:0]     wait_cnt_q,    wait_cnt_d;
    logic [GW-1:0]     gap_cnt_q,     gap_cnt_d;
    logic [IW-1:0]     rr_ptr_q,      rr_ptr_d;

    // Arbitration and data-path helpers
    int                arb_start;
    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [CH_NUM-1:0] win_onehot;
    logic              sel_tx_en;
    logic [7:0]        sel_txd;

    // ------------------------------------------------------------------
    // Select the granted channel's tx_en/txd using the one-hot grant
    // ------------------------------------------------------------------
    always_comb begin
        sel_tx_en = |(ch_tx_en & grant_q);
        sel_txd   = 8'h00;
        for (int i = 0; i < CH_NUM; i++) begin
            if (grant_q[i]) begin
                sel_txd = sel_txd | ch_txd[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pick the winning requester: lowest index, or first index above the
    // last grant (wrapping) in round-robin mode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first; a path
        // that leaves one unassigned would infer a latch.
        arb_start  = int'(rr_ptr_q) + 1;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        if (ARB_MODE != 1 || arb_start >= CH_NUM) begin
            arb_start = 0;
        end
        // Outer loop walks search order, inner loop finds the channel sitting
        // at that position; the first requesting one wins.
        for (int k = 0; k < CH_NUM; k++) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (!win_found && ch_req[i] &&
                    ((i == arb_start + k) || (i == arb_start + k - CH_NUM))) begin
                    win_found     = 1'b1;
                    win_idx       = IW'(i);
                    win_onehot[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state, grant, counter and registered-output computation
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        timeout_d  = 1'b0;
        tx_en_d    = 1'b0;
        txd_d      = 8'h00;
        // Any channel driving tx_en without holding the grant is a collision;
        // its data never reaches the output.
        collision_d = |(ch_tx_en & ~grant_q);

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d    = S_GRANT;
                    grant_d    = win_onehot;
                    rr_ptr_d   = win_idx;   // advances even if this grant times out
                    wait_cnt_d = '0;
                end
            end

            S_GRANT: begin
                // ch_req is deliberately ignored here: only a frame or a
                // timeout releases the grant.
                if (sel_tx_en) begin
                    state_d    = S_SEND;
                    tx_en_d    = 1'b1;
                    txd_d      = sel_txd;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_GAP;
                    grant_d    = '0;
                    timeout_d  = 1'b1;
                    wait_cnt_d = '0;
                    gap_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end

            S_SEND: begin
                // Frames are unbounded; only the granted tx_en falling ends one.
                if (sel_tx_en) begin
                    tx_en_d = 1'b1;
                    txd_d   = sel_txd;
                end else begin
                    state_d   = S_GAP;
                    grant_d   = '0;
                    gap_cnt_d = '0;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register all state and outputs; synchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            tx_en_q     <= 1'b0;
            txd_q       <= 8'h00;
            timeout_q   <= 1'b0;
            collision_q <= 1'b0;
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            rr_ptr_q    <= RR_RST;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            tx_en_q     <= tx_en_d;
            txd_q       <= txd_d;
            timeout_q   <= timeout_d;
            collision_q <= collision_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ch_grant      = grant_q;
    assign gmii_tx_en    = tx_en_q;
    assign gmii_txd      = txd_q;
    assign busy          = (state_q != S_IDLE);
    assign timeout_err   = timeout_q;
    assign collision_err = collision_q;

endmodule

// File: tb/tb_eth_tx_mux_n.sv
// tb_eth_tx_mux_n
// Directed bench for eth_tx_mux_n. Instance A: 2 channels, fixed priority.
// Instance B: 4 channels, round-robin. Inputs change 1 ns after each rising
// edge; outputs are sampled at that same point, i.e. just after the edge.
module tb_eth_tx_mux_n;

    logic        clk = 1'b0;
    logic        rst_n;

    // Instance A: CH_NUM=2, ARB_MODE=0
    logic [1:0]  a_req, a_tx_en, a_grant;
    logic [15:0] a_txd;
    logic        a_gtx_en, a_busy, a_to, a_col;
    logic [7:0]  a_gtxd;

    // Instance B: CH_NUM=4, ARB_MODE=1
    logic [3:0]  b_req, b_tx_en, b_grant;
    logic [31:0] b_txd;
    logic        b_gtx_en, b_busy, b_to, b_col;
    logic [7:0]  b_gtxd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    eth_tx_mux_n #(
        .CH_NUM(2), .ARB_MODE(0), .IFG_CYCLES(12), .START_TIMEOUT(64)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .ch_req(a_req), .ch_tx_en(a_tx_en), .ch_txd(a_txd),
        .ch_grant(a_grant), .gmii_tx_en(a_gtx_en), .gmii_txd(a_gtxd),
        .busy(a_busy), .timeout_err(a_to), .collision_err(a_col)
    );

    eth_tx_mux_n #(
        .CH_NUM(4), .ARB_MODE(1), .IFG_CYCLES(12), .START_TIMEOUT(64)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .ch_req(b_req), .ch_tx_en(b_tx_en), .ch_txd(b_txd),
        .ch_grant(b_grant), .gmii_tx_en(b_gtx_en), .gmii_txd(b_gtxd),
        .busy(b_busy), .timeout_err(b_to), .collision_err(b_col)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cycles;
        int idx;
        logic [3:0] b_exp;

        // ---------------- reset ----------------
        rst_n   = 1'b0;
        a_req   = '0; a_tx_en = '0; a_txd = '0;
        b_req   = '0; b_tx_en = '0; b_txd = '0;
        tick(); tick(); tick();
        check("rst_a_grant",  a_grant,  0);
        check("rst_a_gtx_en", a_gtx_en, 0);
        check("rst_a_gtxd",   a_gtxd,   0);
        check("rst_a_busy",   a_busy,   0);
        check("rst_a_to",     a_to,     0);
        check("rst_a_col",    a_col,    0);
        check("rst_b_grant",  b_grant,  0);
        check("rst_b_busy",   b_busy,   0);
        rst_n = 1'b1;
        tick();
        check("idle_a_busy", a_busy, 0);

        // ---------------- fixed priority, 60-byte frame ----------------
        a_req = 2'b11;
        tick();
        check("prio_grant", a_grant, 2'b01);
        check("prio_busy",  a_busy,  1);
        a_req[0] = 1'b0;                    // ch1 keeps requesting
        for (int i = 0; i < 60; i++) begin
            a_tx_en[0]  = 1'b1;
            a_txd[7:0]  = 8'(8'h20 + i);
            tick();
            check("frame_tx_en", a_gtx_en, 1);
            check("frame_txd",   a_gtxd,   8'(8'h20 + i));
        end
        check("frame_grant_hold", a_grant, 2'b01);
        a_tx_en = '0; a_txd = '0;
        tick();
        check("frame_end_tx_en", a_gtx_en, 0);
        check("frame_end_grant", a_grant,  0);
        check("frame_end_busy",  a_busy,   1);
        for (int i = 0; i < 12; i++) tick();
        check("gap_grant_still0", a_grant,  0);
        check("gap_tx_en",        a_gtx_en, 0);
        check("gap_then_idle",    a_busy,   0);
        tick();
        check("second_grant", a_grant, 2'b10);

        // ---------------- start timeout ----------------
        a_req = '0;
        for (int i = 0; i < 63; i++) tick();
        check("to_not_yet",     a_to,    0);
        check("to_grant_held",  a_grant, 2'b10);
        tick();
        check("to_pulse",       a_to,    1);
        check("to_grant_clear", a_grant, 0);
        check("to_gap_busy",    a_busy,  1);
        tick();
        check("to_one_cycle",   a_to,    0);

        // ---------------- request during GAP ----------------
        a_req[0] = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        check("gapreq_no_grant", a_grant, 0);
        check("gapreq_idle",     a_busy,  0);
        tick();
        check("gapreq_grant",    a_grant, 2'b01);
        a_req = '0;

        // ---------------- collision while ch0 sends ----------------
        for (int j = 0; j < 5; j++) begin
            a_tx_en[0]  = 1'b1;
            a_txd[7:0]  = 8'(8'hA0 + j);
            a_tx_en[1]  = (j == 2);
            a_txd[15:8] = (j == 2) ? 8'hEE : 8'h00;
            tick();
            check("col_txd", a_gtxd, 8'(8'hA0 + j));
            check("col_err", a_col,  (j == 2) ? 1 : 0);
        end
        a_tx_en = '0; a_txd = '0;
        tick();
        check("col_end_tx_en", a_gtx_en, 0);
        check("col_end_err",   a_col,    0);

        // ---------------- reset on 10th byte ----------------
        a_req[1] = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        check("rstf_grant", a_grant, 2'b10);
        for (int j = 0; j < 9; j++) begin
            a_tx_en[1]  = 1'b1;
            a_txd[15:8] = 8'(8'h50 + j);
            tick();
            check("rstf_txd", a_gtxd, 8'(8'h50 + j));
        end
        a_txd[15:8] = 8'h59;
        rst_n = 1'b0;
        tick();
        check("rstf_tx_en", a_gtx_en, 0);
        check("rstf_gtxd",  a_gtxd,   0);
        check("rstf_grant0", a_grant, 0);
        check("rstf_busy",  a_busy,   0);
        check("rstf_col",   a_col,    0);
        rst_n = 1'b1;
        a_tx_en = '0; a_txd = '0;
        tick();
        check("rstf_rearb_grant", a_grant,  2'b10);
        check("rstf_rearb_tx_en", a_gtx_en, 0);
        a_req = '0;

        // ---------------- round-robin on instance B ----------------
        b_req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            idx   = n % 4;
            b_exp = 4'(1 << idx);
            cycles = 0;
            while (b_grant === 4'h0 && cycles < 100) begin
                tick();
                cycles++;
            end
            check("rr_grant", b_grant, b_exp);
            if (n > 0) check("rr_gap_ge_ifg", (cycles >= 12) ? 1 : 0, 1);
            b_tx_en[idx]       = 1'b1;
            b_txd[8*idx +: 8]  = 8'(8'h30 + n);
            tick();
            check("rr_tx_en", b_gtx_en, 1);
            check("rr_txd",   b_gtxd,   8'(8'h30 + n));
            b_tx_en = '0; b_txd = '0;
            tick();
            check("rr_release", b_grant, 0);
        end
        b_req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
